// File: rtl/hwpe_aes_pkg.sv
// Shared types and constants for the HWPE-to-AES datapath.
package hwpe_aes_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_N_WORDS = AES_BLK_W / AES_WORD_W;

  typedef logic [$clog2(AES_N_WORDS)-1:0] stack_cnt_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0]   data;
    logic [AES_N_WORDS-1:0] strb;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/word_stacker_chk.sv
// Protocol and output-invariant checks for word_stacker.
module word_stacker_chk #(
  parameter int unsigned N_WORDS = 4
) (
  input logic                       clk_i,
  input logic                       rst_i,
  input logic                       msb_first_i,
  input logic [$clog2(N_WORDS)-1:0] cnt,
  input logic                       valid_o,
  input logic [N_WORDS-1:0]         strb_o,
  input logic                       last_o
);

  // lane order may only move between beats
  a_msb_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt != '0) |-> $stable(msb_first_i));

  a_strb_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o |-> (strb_o != '0));

  a_full_unless_last: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !last_o) |-> (strb_o == '1));

endmodule

// File: rtl/word_stacker.sv
// N:1 stream width converter: packs N_WORDS input words into one wide beat with
// runtime lane order, partial-beat flush with lane strobe and last marking.
module word_stacker
  import hwpe_aes_pkg::*;
#(
  parameter int unsigned IN_W    = AES_WORD_W,
  parameter int unsigned N_WORDS = AES_N_WORDS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    enable_i,
  input  logic                    msb_first_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [IN_W-1:0]         word_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [N_WORDS*IN_W-1:0] word_o,
  output logic [N_WORDS-1:0]      strb_o,
  output logic                    last_o
);

  localparam int unsigned CNT_W = $clog2(N_WORDS);
  localparam int unsigned OUT_W = N_WORDS * IN_W;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [OUT_W-1:0]   data;
    logic [N_WORDS-1:0] strb;
    logic               last;
  } lbeat_t;

  localparam cnt_t CNT_LAST = cnt_t'(N_WORDS - 1);

  function automatic cnt_t lane_idx(input cnt_t cnt, input logic msb_first);
    cnt_t idx;
    if (msb_first) begin
      idx = CNT_LAST - cnt;
    end else begin
      idx = cnt;
    end
    return idx;
  endfunction

  // assembly stage
  logic [OUT_W-1:0]   acc_r;
  logic [N_WORDS-1:0] acc_strb_r;
  cnt_t               cnt_r;
  logic               flush_pend_r;

  // output stage
  lbeat_t             beat_r;
  logic               valid_r;

  logic               out_free_s;
  logic               ready_s;
  logic               accept_s;
  logic               complete_s;
  logic               flush_want_s;
  logic               load_s;
  cnt_t               lane_s;
  logic [OUT_W-1:0]   acc_next_s;
  logic [N_WORDS-1:0] strb_next_s;

  // Handshake decode and next assembly contents including the word accepted this cycle
  always_comb begin
    out_free_s  = ~valid_r | ready_i;
    ready_s     = enable_i & ((cnt_r != CNT_LAST) | out_free_s) & ~flush_pend_r;
    accept_s    = valid_i & ready_s;
    lane_s      = lane_idx(cnt_r, msb_first_i);
    acc_next_s  = acc_r;
    strb_next_s = acc_strb_r;
    if (accept_s) begin
      acc_next_s[lane_s*IN_W +: IN_W] = word_i;
      strb_next_s[lane_s]             = 1'b1;
    end else begin
      acc_next_s  = acc_r;
      strb_next_s = acc_strb_r;
    end
    complete_s = accept_s & (cnt_r == CNT_LAST);
    // A flush only matters when there is something to emit, or one is already waiting
    flush_want_s = enable_i & (flush_pend_r | (flush_i & ((cnt_r != '0) | accept_s)));
    load_s       = complete_s | (flush_want_s & out_free_s);
  end

  // Assembly register: fill counter, partial data, lane mask, pending flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r        <= '0;
      acc_strb_r   <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
    end else if (clr_i || load_s) begin
      acc_r        <= '0;
      acc_strb_r   <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
    end else if (flush_want_s) begin
      // output stage busy: keep the partial (plus any word taken now) until it drains
      acc_r        <= acc_next_s;
      acc_strb_r   <= strb_next_s;
      cnt_r        <= accept_s ? cnt_r + cnt_t'(1) : cnt_r;
      flush_pend_r <= 1'b1;
    end else if (accept_s) begin
      acc_r      <= acc_next_s;
      acc_strb_r <= strb_next_s;
      cnt_r      <= cnt_r + cnt_t'(1);
    end
  end

  // Output register: load a finished or flushed beat, drop it once taken downstream
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_r  <= '0;
      valid_r <= 1'b0;
    end else if (clr_i) begin
      beat_r  <= '0;
      valid_r <= 1'b0;
    end else if (load_s) begin
      beat_r.data <= acc_next_s;
      beat_r.strb <= strb_next_s;
      beat_r.last <= flush_want_s;
      valid_r     <= 1'b1;
    end else if (enable_i && valid_r && ready_i) begin
      beat_r  <= '0;
      valid_r <= 1'b0;
    end
  end

  assign ready_o = ready_s;
  assign valid_o = valid_r;
  assign word_o  = beat_r.data;
  assign strb_o  = beat_r.strb;
  assign last_o  = beat_r.last;

endmodule

// File: tb/tb_word_stacker.sv
// Scoreboard bench for word_stacker (IN_W=32, N_WORDS=4).
module tb_word_stacker;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clr_i = 1'b0;
  logic         enable_i = 1'b1;
  logic         msb_first_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [31:0]  word_i = 32'h0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [127:0] word_o;
  logic [3:0]   strb_o;
  logic         last_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   strb;
    logic         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk_i = ~clk_i;

  word_stacker #(.IN_W(32), .N_WORDS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
    .msb_first_i(msb_first_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .word_i(word_i), .valid_o(valid_o), .ready_i(ready_i),
    .word_o(word_o), .strb_o(strb_o), .last_o(last_o)
  );

  word_stacker_chk #(.N_WORDS(4)) u_chk (
    .clk_i(clk_i), .rst_i(rst_i), .msb_first_i(msb_first_i), .cnt(dut.cnt_r),
    .valid_o(valid_o), .strb_o(strb_o), .last_o(last_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [3:0] s, input logic l);
    exp_t e;
    e.data = d;
    e.strb = s;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // offer one word, wait (bounded) for acceptance; waits = cycles stalled
  task automatic send(input logic [31:0] w, output int waits);
    valid_i = 1'b1;
    word_i  = w;
    waits   = 0;
    #1;
    while (!ready_o && waits < 100) begin
      step();
      waits++;
    end
    if (!ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: ready_o=0, expected 1 within 100 cycles");
    end
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: every downstream transfer is matched against the scoreboard head
  always @(negedge clk_i) begin
    if (!rst_i && !clr_i && enable_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_beat: got %h strb %h last %b, expected none", word_o, strb_o, last_o);
      end else begin
        mon_e = sb.pop_front();
        check("beat_data", word_o, mon_e.data);
        check("beat_strb", 128'(strb_o), 128'(mon_e.strb));
        check("beat_last", 128'(last_o), 128'(mon_e.last));
      end
    end
  end

  initial begin
    int w;
    #12;
    check("rst_valid", 128'(valid_o), 128'(1'b0));
    check("rst_word", word_o, 128'h0);
    check("rst_strb", 128'(strb_o), 128'h0);
    check("rst_last", 128'(last_o), 128'h0);
    step();
    rst_i = 1'b0;
    step();

    // 1: msb-first packing, one-cycle latency, single valid cycle
    msb_first_i = 1'b1;
    push_exp(128'h00112233_44556677_8899AABB_CCDDEEFF, 4'hF, 1'b0);
    send(32'h00112233, w);
    send(32'h44556677, w);
    send(32'h8899AABB, w);
    check("t1_not_early", 128'(valid_o), 128'(1'b0));
    send(32'hCCDDEEFF, w);
    check("t1_latency", 128'(valid_o), 128'(1'b1));
    step();
    check("t1_one_cycle", 128'(valid_o), 128'(1'b0));

    // 2: lsb-first packing
    msb_first_i = 1'b0;
    push_exp(128'hCCDDEEFF_8899AABB_44556677_00112233, 4'hF, 1'b0);
    send(32'h00112233, w);
    send(32'h44556677, w);
    send(32'h8899AABB, w);
    send(32'hCCDDEEFF, w);
    step();

    // 3: eight words back to back, ready_o must never drop
    push_exp(128'hA0000003_A0000002_A0000001_A0000000, 4'hF, 1'b0);
    push_exp(128'hA0000007_A0000006_A0000005_A0000004, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(32'hA0000000 + 32'(i), w);
      check("t3_no_stall", 128'(w), 128'h0);
    end
    step();
    step();

    // 4: downstream stall blocks the completing word and holds beat 1
    ready_i = 1'b0;
    push_exp(128'h00000004_00000003_00000002_00000001, 4'hF, 1'b0);
    push_exp(128'h00000008_00000007_00000006_00000005, 4'hF, 1'b0);
    for (int i = 1; i <= 7; i++) send(32'(i), w);
    valid_i = 1'b1;
    word_i  = 32'h00000008;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_ready_blocked", 128'(ready_o), 128'(1'b0));
      check("t4_hold_data", word_o, 128'h00000004_00000003_00000002_00000001);
      step();
    end
    ready_i = 1'b1;
    #1;
    check("t4_ready_back", 128'(ready_o), 128'(1'b1));
    step();
    valid_i = 1'b0;
    check("t4_no_bubble", 128'(valid_o), 128'(1'b1));
    step();
    step();

    // enable low: handshakes frozen, beat stays visible
    ready_i = 1'b0;
    push_exp(128'h0000000C_0000000B_0000000A_00000009, 4'hF, 1'b0);
    for (int i = 9; i <= 12; i++) send(32'(i), w);
    enable_i = 1'b0;
    ready_i  = 1'b1;
    #1;
    check("en_ready_off", 128'(ready_o), 128'(1'b0));
    step();
    step();
    check("en_valid_held", 128'(valid_o), 128'(1'b1));
    enable_i = 1'b1;
    step();
    step();
    check("en_drained", 128'(valid_o), 128'(1'b0));

    // 5: partial flush msb-first, then flush with nothing buffered
    msb_first_i = 1'b1;
    push_exp(128'hDEADBEEF_CAFEF00D_00000000_00000000, 4'b1100, 1'b1);
    send(32'hDEADBEEF, w);
    send(32'hCAFEF00D, w);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t5_flush_valid", 128'(valid_o), 128'(1'b1));
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t5_empty_flush", 128'(valid_o), 128'(1'b0));
    step();
    check("t5_empty_flush2", 128'(valid_o), 128'(1'b0));

    // flush together with the first word of a beat
    msb_first_i = 1'b0;
    push_exp(128'h00000000_00000000_00000000_13579BDF, 4'b0001, 1'b1);
    flush_i = 1'b1;
    send(32'h13579BDF, w);
    flush_i = 1'b0;
    step();

    // flush together with the completing word
    push_exp(128'h00000024_00000023_00000022_00000021, 4'hF, 1'b1);
    send(32'h00000021, w);
    send(32'h00000022, w);
    send(32'h00000023, w);
    flush_i = 1'b1;
    send(32'h00000024, w);
    flush_i = 1'b0;
    step();

    // flush while the output stage is busy: pends, blocks input, later drains
    ready_i = 1'b0;
    push_exp(128'h00000034_00000033_00000032_00000031, 4'hF, 1'b0);
    push_exp(128'h00000000_00000000_00000000_00000035, 4'b0001, 1'b1);
    for (int i = 49; i <= 53; i++) send(32'(i), w);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t5_pend_block", 128'(ready_o), 128'(1'b0));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    step();
    check("t5_pend_done", 128'(valid_o), 128'(1'b0));

    // 6: async reset mid-beat, then sync clear mid-beat
    ready_i = 1'b0;
    for (int i = 65; i <= 70; i++) send(32'(i), w);
    check("t6_pre_valid", 128'(valid_o), 128'(1'b1));
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", 128'(valid_o), 128'(1'b0));
    check("t6_rst_word", word_o, 128'h0);
    check("t6_rst_strb", 128'(strb_o), 128'h0);
    rst_i = 1'b0;
    sb.delete();
    ready_i = 1'b1;
    push_exp(128'h00000054_00000053_00000052_00000051, 4'hF, 1'b0);
    for (int i = 81; i <= 84; i++) send(32'(i), w);
    step();

    ready_i = 1'b0;
    for (int i = 97; i <= 102; i++) send(32'(i), w);
    clr_i = 1'b1;
    #1;
    check("t6_clr_sync", 128'(valid_o), 128'(1'b1));
    step();
    clr_i = 1'b0;
    check("t6_clr_valid", 128'(valid_o), 128'(1'b0));
    check("t6_clr_word", word_o, 128'h0);
    ready_i = 1'b1;
    push_exp(128'h00000074_00000073_00000072_00000071, 4'hF, 1'b0);
    for (int i = 113; i <= 116; i++) send(32'(i), w);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", 128'(sb.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
